tf_out_decimator: RTL and testbench
===================================

# tf_out_decimator

Downstream stage for the fixed-point output of a compiled msdsl transfer-function model. Consumes one signed svreal fixed-point sample per enabled clock and accumulates non-overlapping windows of 2^LOG2_DEC samples. Emits the rounded window mean over a valid/ready handshake, so a capture FIFO or host interface can drain model output at a reduced rate. Flags any result lost to back-pressure with a sticky overflow bit.

## Interface
- WIDTH, 25: signed fixed-point width, matching the model output signal.
- EXPONENT, -16: svreal exponent of in_data and out_data; they share one format.
- LOG2_DEC, 3: log2 of window length N; legal range 1..8.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous assert and active-low; outputs return to reset values immediately on assert.
- in_data  input  WIDTH  signed model output sample.
- in_valid  input  1  sample is accepted on any clk edge where this is high; there is no ready back to the model.
- out_data  output  WIDTH  signed window mean, same EXPONENT; reset 0.
- out_valid  output  1  out_data holds an unconsumed result; reset 0.
- out_ready  input  1  consumer accepts out_data on an edge where out_valid && out_ready.
- overflow  output  1  sticky; set when a completed window is dropped; reset 0; cleared only by rst.
- win_count  output  LOG2_DEC  samples accumulated in the current window; reset 0.

## Operation
- Accumulator acc is signed, WIDTH+LOG2_DEC bits, and cannot overflow.
- Each accepted sample is sign-extended and added into acc, and win_count increments.
- On the Nth accepted sample (win_count == N-1 && in_valid), form the sum S = acc + sample.
- Mean = (S + 2^(LOG2_DEC-1)) >>> LOG2_DEC: arithmetic shift, round half toward +inf. Truncate to WIDTH bits; the result always fits.
- On that same edge, acc loads 0 and win_count wraps to 0. A new window starts on the next accepted sample, with no gap.
- The output register holds a single entry, with two states:
  - EMPTY: out_valid=0.
  - HELD: out_valid=1.
- Transitions:
  - EMPTY + window complete -> HELD, load mean.
  - HELD + out_ready, no completion -> EMPTY.
  - HELD + out_ready + completion on the same edge -> HELD with the new mean. The old result is consumed and overflow is not set.
  - HELD + no out_ready + completion -> stay HELD, keep the old out_data, discard the new mean, set overflow.
- While HELD, out_data is stable until the handshake completes.
- in_valid low: acc, win_count and the output state are unchanged, apart from the handshake.
- Reset mid-window discards the partial acc. The first window after release begins with the first accepted sample.

## Timing
- Latency: out_valid rises on the same edge that accepts the Nth sample. The result is visible in the following cycle.
- Throughput: one result per N accepted samples. A consumer holding out_ready high never causes overflow.
- out_ready is ignored while out_valid=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rst release is synchronised by the surrounding system. The block samples the first in_valid on the first edge after deassert.

## Structure
- The shared package tf_stage_pkg holds:
  - the localparam function for accumulator width;
  - the output-state enum (EMPTY, HELD);
  - the rounding helper function.
- Sub-module tf_out_skid: a one-entry holding register with valid/ready and drop detection. It is reusable by other model-output stages.
- The top level holds the accumulator, the window counter and the rounding logic.

## Test plan
- LOG2_DEC=3, EXPONENT=-16, out_ready=1, eight samples of 65536 (1.0) -> out_valid for one cycle, out_data=65536, win_count back at 0, overflow=0.
- Samples 0,1,0,1,0,1,0,1 (N=8, sum 4):
  - mean = (4+4)>>>3 = 1 -> out_data=1.
  - Repeat with sum -4 -> out_data=0, because rounding is toward +inf.
- in_valid toggling 1,0,1,0 over 16 cycles -> exactly one result, after the 8th accepted sample, with value equal to the mean of the accepted samples only.
- out_ready=0 over two full windows with means 100 then 200:
  - out_data stays 100 and overflow goes to 1.
  - Raising out_ready consumes 100, then out_valid=0.
- Window completes on the same edge as out_ready=1 while HELD: the old result is consumed, the new mean is loaded, and overflow stays 0.
- Assert rst after 5 samples:
  - out_valid, overflow, win_count and out_data go to 0 without waiting for a clock edge.
  - After release, 8 samples of -65536 give out_data=-65536.

Source files
------------

// File: rtl/tf_stage_pkg.sv
// Shared types and helpers for msdsl model-output stages.
package tf_stage_pkg;

  typedef enum logic {EMPTY, HELD} out_state_e;

  // A sum of 2^log2_dec signed width-bit samples needs log2_dec guard bits.
  function automatic int acc_width(input int width, input int log2_dec);
    return width + log2_dec;
  endfunction

  // Window mean with round-half-toward-+inf: (s + 2^(k-1)) >>> k.
  function automatic logic signed [63:0] round_mean(input logic signed [63:0] s,
                                                     input int log2_dec);
    return (s + (64'sd1 <<< (log2_dec - 1))) >>> log2_dec;
  endfunction

endpackage

// File: rtl/tf_out_skid.sv
// One-entry valid/ready holding register; a push that finds it full and not
// draining is dropped and latches a sticky drop flag.
module tf_out_skid
  import tf_stage_pkg::*;
#(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);

  out_state_e   state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         drop_q, drop_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop_d  = drop_q;
    case (state_q)
      EMPTY: if (push_i) begin
        state_d = HELD;
        data_d  = data_i;
      end
      HELD: begin
        if (ready_i) begin
          // Consume and refill on the same edge keeps the entry occupied.
          if (push_i) data_d = data_i;
          else        state_d = EMPTY;
        end else if (push_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid_o = (state_q == HELD);
  assign data_o  = data_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/tf_out_decimator.sv
// Averages non-overlapping windows of 2^LOG2_DEC model-output samples and
// hands the rounded mean to a one-entry valid/ready output register.
module tf_out_decimator
  import tf_stage_pkg::*;
#(
  parameter int WIDTH    = 25,
  parameter int EXPONENT = -16,
  parameter int LOG2_DEC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [LOG2_DEC-1:0] win_count
);

  localparam int AW = acc_width(WIDTH, LOG2_DEC);
  // Input and output share one fixed-point format, so no rescaling is needed.
  localparam int unused_exponent = EXPONENT;

  logic signed [AW-1:0]    acc_q, acc_d;
  logic [LOG2_DEC-1:0]     cnt_q, cnt_d;
  logic signed [AW-1:0]    sample_ext, sum;
  logic signed [63:0]      sum_wide, mean_wide;
  logic [WIDTH-1:0]        mean;
  logic                    win_done;
  logic                    unused_mean_hi;

  assign sample_ext = {{LOG2_DEC{in_data[WIDTH-1]}}, in_data};
  assign sum        = acc_q + sample_ext;
  assign win_done   = in_valid && (&cnt_q);
  assign sum_wide   = 64'(sum);
  assign mean_wide  = round_mean(sum_wide, LOG2_DEC);
  assign mean       = mean_wide[WIDTH-1:0];
  assign unused_mean_hi = ^mean_wide[63:WIDTH];

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = cnt_q + LOG2_DEC'(1);
      acc_d = win_done ? '0 : sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  tf_out_skid #(.W(WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (win_done),
    .data_i  (mean),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .drop_o  (overflow)
  );

  assign win_count = cnt_q;

endmodule

// File: tb/tb_tf_out_decimator.sv
// Directed vectors and hand-written corner sequences for tf_out_decimator.
module tb_tf_out_decimator;

  localparam int WIDTH    = 25;
  localparam int EXPONENT = -16;
  localparam int LOG2_DEC = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [WIDTH-1:0]    in_data = '0;
  logic                in_valid = 1'b0;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                overflow;
  logic [LOG2_DEC-1:0] win_count;

  int n_cmp = 0;
  int n_bad = 0;

  tf_out_decimator #(.WIDTH(WIDTH), .EXPONENT(EXPONENT), .LOG2_DEC(LOG2_DEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .win_count (win_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    s[8];
    int    exp;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_n(input int v, input int n);
    for (int i = 0; i < n; i++) push(v);
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  initial begin
    tbl[0].nm = "ones";      tbl[0].s = '{65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536}; tbl[0].exp = 65536;
    tbl[1].nm = "sum4";      tbl[1].s = '{0, 1, 0, 1, 0, 1, 0, 1};                                 tbl[1].exp = 1;
    tbl[2].nm = "sum_m4";    tbl[2].s = '{0, -1, 0, -1, 0, -1, 0, -1};                             tbl[2].exp = 0;
    tbl[3].nm = "sum3";      tbl[3].s = '{3, 0, 0, 0, 0, 0, 0, 0};                                 tbl[3].exp = 0;
    tbl[4].nm = "sum_m5";    tbl[4].s = '{-5, 0, 0, 0, 0, 0, 0, 0};                                tbl[4].exp = -1;
    tbl[5].nm = "sum12";     tbl[5].s = '{12, 0, 0, 0, 0, 0, 0, 0};                                tbl[5].exp = 2;
    tbl[6].nm = "sum11";     tbl[6].s = '{5, 6, 0, 0, 0, 0, 0, 0};                                 tbl[6].exp = 1;
    tbl[7].nm = "max_pos";   for (int i = 0; i < 8; i++) tbl[7].s[i] = 16777215;                   tbl[7].exp = 16777215;
    tbl[8].nm = "max_neg";   for (int i = 0; i < 8; i++) tbl[8].s[i] = -16777216;                  tbl[8].exp = -16777216;

    // Reset state before any clock edge
    #2;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", sdata(), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_cnt", int'(win_count), 0);
    step();
    rst = 1'b1;

    // Table vectors with a consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) check({tbl[v].nm, "_midvalid"}, int'(out_valid), 0);
        push(tbl[v].s[i]);
      end
      check({tbl[v].nm, "_valid"}, int'(out_valid), 1);
      check({tbl[v].nm, "_data"}, sdata(), tbl[v].exp);
      check({tbl[v].nm, "_cnt"}, int'(win_count), 0);
      check({tbl[v].nm, "_ovf"}, int'(overflow), 0);
      step();
      check({tbl[v].nm, "_drained"}, int'(out_valid), 0);
    end

    // in_valid toggling: only accepted samples count (10..80, mean 45)
    begin
      int nres = 0;
      int rval = 0;
      for (int c = 0; c < 16; c++) begin
        in_valid = (c % 2 == 0);
        in_data  = in_valid ? WIDTH'((c / 2 + 1) * 10) : WIDTH'(1000000);
        step();
        if (out_valid) begin
          nres++;
          rval = sdata();
          check("toggle_at8th", c, 14);
        end
      end
      in_valid = 1'b0;
      check("toggle_nres", nres, 1);
      check("toggle_data", rval, 45);
    end

    // Back-pressure over two windows: old result held, new one dropped
    out_ready = 1'b0;
    push_n(100, 8);
    check("bp_valid1", int'(out_valid), 1);
    check("bp_data1", sdata(), 100);
    check("bp_ovf1", int'(overflow), 0);
    push_n(200, 8);
    check("bp_valid2", int'(out_valid), 1);
    check("bp_data2", sdata(), 100);
    check("bp_ovf2", int'(overflow), 1);
    out_ready = 1'b1;
    step();
    check("bp_drained", int'(out_valid), 0);
    check("bp_ovf_sticky", int'(overflow), 1);

    // Asynchronous reset mid-window
    push_n(5000, 5);
    check("mid_cnt", int'(win_count), 5);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_data", sdata(), 0);
    check("arst_ovf", int'(overflow), 0);
    check("arst_cnt", int'(win_count), 0);
    step();
    rst = 1'b1;
    push_n(-65536, 8);
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_data", sdata(), -65536);
    step();

    // Window completes on the same edge the held result is consumed
    out_ready = 1'b0;
    push_n(100, 8);
    check("same_held", sdata(), 100);
    push_n(300, 7);
    check("same_still_held", sdata(), 100);
    out_ready = 1'b1;
    push(300);
    check("same_valid", int'(out_valid), 1);
    check("same_data", sdata(), 300);
    check("same_ovf", int'(overflow), 0);
    step();
    check("same_drained", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
